// File: rtl/store_buffer.sv
// Posted-write store buffer between the core data port and data memory.
// Stores enter a DEPTH-entry FIFO in one cycle; a two-state drain FSM
// writes them to memory over a req/ack handshake, strictly in FIFO order.
// Optional feature macro: STBUF_FWD_EN
//   defined   : loads forward data from the youngest matching buffered store
//   undefined : loads stall while the buffer holds any store
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wd,
  output logic          cpu_stall,
  output logic          cpu_fwd_hit,
  output logic [DW-1:0] cpu_fwd_data,
  output logic          mem_req,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic          mem_ack
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  // Entry storage (datapath only, not reset)
  logic [AW-1:0]    adr_q [DEPTH];
  logic [AW-1:0]    adr_d [DEPTH];
  logic [DW-1:0]    wd_q  [DEPTH];
  logic [DW-1:0]    wd_d  [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] head_nxt;
  logic [CW-1:0] count_q, count_d;

  state_e        state_q, state_d;
  logic [AW-1:0] mem_adr_q, mem_adr_d;
  logic [DW-1:0] mem_wd_q, mem_wd_d;

  logic full;
  logic enq;
  logic deq;
  logic load_stall;

  assign full     = (count_q == CW'(DEPTH));
  // A full buffer never accepts, even when an ack frees a slot this cycle;
  // this keeps mem_ack off the cpu_stall path.
  assign enq      = cpu_we & ~full & ~reset;
  assign deq      = (state_q == StBusy) & mem_ack;
  assign head_nxt = head_q + PW'(1);

  assign mem_req  = (state_q == StBusy);
  assign mem_adr  = mem_adr_q;
  assign mem_wd   = mem_wd_q;

  // Next-state for entry storage, valid bits, pointers and occupancy
  always_comb begin
    adr_d   = adr_q;
    wd_d    = wd_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) begin
      adr_d[tail_q]   = cpu_adr;
      wd_d[tail_q]    = cpu_wd;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PW'(1);
    end
    if (deq) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_nxt;
    end
    if (enq && !deq) begin
      count_d = count_q + CW'(1);
    end else if (!enq && deq) begin
      count_d = count_q - CW'(1);
    end
  end

  // Drain FSM: registers the entry presented to memory so it is stable while mem_req is high
  always_comb begin
    state_d   = state_q;
    mem_adr_d = mem_adr_q;
    mem_wd_d  = mem_wd_q;
    unique case (state_q)
      StIdle: begin
        // Idle implies an empty buffer, so the incoming store is the new head.
        if (enq) begin
          state_d   = StBusy;
          mem_adr_d = cpu_adr;
          mem_wd_d  = cpu_wd;
        end
      end
      StBusy: begin
        if (mem_ack) begin
          if (count_d != '0) begin
            // With one entry left the next head is the store arriving this cycle.
            if (count_q == CW'(1)) begin
              mem_adr_d = cpu_adr;
              mem_wd_d  = cpu_wd;
            end else begin
              mem_adr_d = adr_q[head_nxt];
              mem_wd_d  = wd_q[head_nxt];
            end
          end else begin
            state_d   = StIdle;
            mem_adr_d = '0;
            mem_wd_d  = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      valid_q   <= '0;
      mem_adr_q <= '0;
      mem_wd_q  <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      mem_adr_q <= mem_adr_d;
      mem_wd_q  <= mem_wd_d;
    end
  end

  // Entry storage registers
  always_ff @(posedge clk) begin
    adr_q <= adr_d;
    wd_q  <= wd_d;
  end

`ifdef STBUF_FWD_EN
  logic [PW-1:0] fwd_idx;
  logic          fwd_any;
  logic [DW-1:0] fwd_sel;

  // Search oldest to youngest so the last word-address match (closest to tail) wins
  always_comb begin
    fwd_idx = head_q;
    fwd_any = 1'b0;
    fwd_sel = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if (valid_q[fwd_idx] && (adr_q[fwd_idx][AW-1:2] == cpu_adr[AW-1:2])) begin
        fwd_any = 1'b1;
        fwd_sel = wd_q[fwd_idx];
      end
    end
  end

  assign cpu_fwd_hit  = cpu_re & fwd_any;
  assign cpu_fwd_data = (cpu_re & fwd_any) ? fwd_sel : '0;
  // A miss means memory already holds the newest value for that word.
  assign load_stall   = 1'b0;
`else
  assign cpu_fwd_hit  = 1'b0;
  assign cpu_fwd_data = '0;
  // Without forwarding a load waits until every buffered store has drained.
  assign load_stall   = cpu_re & (|valid_q);
`endif

  assign cpu_stall = (cpu_we & full) | load_stall;

  // Structural invariants of the buffer
  a_count_le_depth : assert property (@(posedge clk) disable iff (reset)
    count_q <= CW'(DEPTH));
  a_req_implies_data : assert property (@(posedge clk) disable iff (reset)
    mem_req |-> (count_q != '0));
  a_req_stable : assert property (@(posedge clk) disable iff (reset)
    (mem_req && !mem_ack) |=> (mem_req && $stable(mem_adr) && $stable(mem_wd)));

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer. A memory-side monitor pops the
// expected {adr, wd} of every accepted drain from a scoreboard queue filled
// as stores are issued; each scenario task also checks handshake and stall
// behaviour inline.
module tb_store_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_we;
  logic          cpu_re;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wd;
  logic          cpu_stall;
  logic          cpu_fwd_hit;
  logic [DW-1:0] cpu_fwd_data;
  logic          mem_req;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wd;
  logic          mem_ack;

  int n_checks  = 0;
  int n_fail    = 0;
  int n_drained = 0;
  bit mon_en    = 1'b1;

  logic [AW+DW-1:0] sb_q[$];
  logic [AW+DW-1:0] mon_exp;

  always #5 clk = ~clk;

  store_buffer #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_we      (cpu_we),
    .cpu_re      (cpu_re),
    .cpu_adr     (cpu_adr),
    .cpu_wd      (cpu_wd),
    .cpu_stall   (cpu_stall),
    .cpu_fwd_hit (cpu_fwd_hit),
    .cpu_fwd_data(cpu_fwd_data),
    .mem_req     (mem_req),
    .mem_adr     (mem_adr),
    .mem_wd      (mem_wd),
    .mem_ack     (mem_ack)
  );

  // Memory model: every accepted drain must be the oldest outstanding store
  always @(negedge clk) begin
    if (mon_en && mem_req && mem_ack) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL drain_unexpected: got adr=%h wd=%h, required no drain", mem_adr, mem_wd);
      end else begin
        mon_exp = sb_q.pop_front();
        if ({mem_adr, mem_wd} !== mon_exp) begin
          n_fail++;
          $display("FAIL drain_order: got adr=%h wd=%h, required adr=%h wd=%h",
                   mem_adr, mem_wd, mon_exp[AW+DW-1:DW], mon_exp[DW-1:0]);
        end
        n_drained++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_we  = 1'b0;
    cpu_re  = 1'b0;
    cpu_adr = '0;
    cpu_wd  = '0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    mem_ack = 1'b0;
    idle_inputs();
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_mem_req: got %b, required 0", mem_req);
    end
    n_checks++;
    if ({mem_adr, mem_wd} !== '0) begin
      n_fail++; $display("FAIL reset_mem_bus: got %h/%h, required 0/0", mem_adr, mem_wd);
    end
    n_checks++;
    if ({cpu_stall, cpu_fwd_hit, cpu_fwd_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_cpu_outs: got stall=%b hit=%b data=%h, required all 0",
               cpu_stall, cpu_fwd_hit, cpu_fwd_data);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int base;
    base    = n_drained;
    mem_ack = 1'b1;
    cpu_we  = 1'b1;
    cpu_adr = 32'h0000_0FC4;
    cpu_wd  = 32'h0000_0011;
    sb_q.push_back({cpu_adr, cpu_wd});
    @(negedge clk);
    n_checks++;
    if (cpu_stall !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL single_enq_cycle: got stall=%b req=%b, required 0/0", cpu_stall, mem_req);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || mem_adr !== 32'h0FC4 || mem_wd !== 32'h11) begin
      n_fail++;
      $display("FAIL single_req: got req=%b adr=%h wd=%h, required 1/00000fc4/00000011",
               mem_req, mem_adr, mem_wd);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL single_req_drop: got %b, required 0", mem_req);
    end
    n_checks++;
    if (n_drained - base != 1) begin
      n_fail++; $display("FAIL single_drain_cnt: got %0d, required 1", n_drained - base);
    end
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_fill_stall();
    int base;
    base    = n_drained;
    mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cpu_we  = 1'b1;
      cpu_adr = 32'h100 + 32'(4 * k);
      cpu_wd  = 32'hA0 + 32'(k);
      @(negedge clk);
      n_checks++;
      if (cpu_stall !== 1'b0) begin
        n_fail++; $display("FAIL fill_nostall[%0d]: got %b, required 0", k, cpu_stall);
      end
      sb_q.push_back({cpu_adr, cpu_wd});
      tick();
    end
    cpu_adr = 32'h110;
    cpu_wd  = 32'hA4;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (cpu_stall !== 1'b1) begin
        n_fail++; $display("FAIL fill_stall[%0d]: got %b, required 1", k, cpu_stall);
      end
      tick();
    end
    mem_ack = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL fill_stall_ack_cycle: got %b, required 1", cpu_stall);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (cpu_stall !== 1'b0) begin
      n_fail++; $display("FAIL fill_retry: got %b, required 0", cpu_stall);
    end
    sb_q.push_back({cpu_adr, cpu_wd});
    tick();
    idle_inputs();
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      n_checks++;
      if (mem_req !== 1'b1) begin
        n_fail++; $display("FAIL fill_drain_req[%0d]: got %b, required 1", j, mem_req);
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL fill_drain_end: got %b, required 0", mem_req);
    end
    n_checks++;
    if (n_drained - base != 5 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL fill_drain_cnt: got %0d drained, %0d pending, required 5, 0",
               n_drained - base, sb_q.size());
    end
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_full_ack_pulse();
    int base;
    int c;
    base    = n_drained;
    mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cpu_we  = 1'b1;
      cpu_adr = 32'h200 + 32'(4 * k);
      cpu_wd  = 32'hB0 + 32'(k);
      sb_q.push_back({cpu_adr, cpu_wd});
      tick();
    end
    cpu_adr = 32'h210;
    cpu_wd  = 32'hB4;
    @(negedge clk);
    n_checks++;
    if (cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL pulse_full_stall: got %b, required 1", cpu_stall);
    end
    tick();
    mem_ack = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL pulse_ack_cycle_stall: got %b, required 1", cpu_stall);
    end
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cpu_stall !== 1'b0) begin
      n_fail++; $display("FAIL pulse_enq_after_ack: got %b, required 0", cpu_stall);
    end
    sb_q.push_back({cpu_adr, cpu_wd});
    tick();
    cpu_adr = 32'h214;
    cpu_wd  = 32'hB5;
    @(negedge clk);
    n_checks++;
    if (cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL pulse_refull: got %b, required 1", cpu_stall);
    end
    tick();
    idle_inputs();
    mem_ack = 1'b1;
    c = 0;
    @(negedge clk);
    while (mem_req && c < 20) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL pulse_drain_timeout: got req=%b after 20 cycles, required 0", mem_req);
    end
    n_checks++;
    if (n_drained - base != 5 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL pulse_drain_cnt: got %0d drained, %0d pending, required 5, 0",
               n_drained - base, sb_q.size());
    end
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_load();
    mem_ack = 1'b0;
    cpu_we  = 1'b1;
    cpu_adr = 32'h64;
    cpu_wd  = 32'h5;
    sb_q.push_back({cpu_adr, cpu_wd});
    tick();
    cpu_wd  = 32'h7;
    sb_q.push_back({cpu_adr, cpu_wd});
    tick();
    cpu_we  = 1'b0;
    cpu_re  = 1'b1;
    cpu_adr = 32'h66;
    cpu_wd  = '0;
    @(negedge clk);
`ifdef STBUF_FWD_EN
    n_checks++;
    if (cpu_fwd_hit !== 1'b1 || cpu_fwd_data !== 32'h7 || cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL load_fwd_hit: got hit=%b data=%h stall=%b, required 1/00000007/0",
               cpu_fwd_hit, cpu_fwd_data, cpu_stall);
    end
    tick();
    cpu_adr = 32'h68;
    @(negedge clk);
    n_checks++;
    if (cpu_fwd_hit !== 1'b0 || cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL load_fwd_miss: got hit=%b stall=%b, required 0/0", cpu_fwd_hit, cpu_stall);
    end
    tick();
    cpu_adr = 32'h66;
    mem_ack = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      n_checks++;
      if (cpu_fwd_hit !== 1'b1 || cpu_fwd_data !== 32'h7) begin
        n_fail++;
        $display("FAIL load_fwd_inflight[%0d]: got hit=%b data=%h, required 1/00000007",
                 j, cpu_fwd_hit, cpu_fwd_data);
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (cpu_fwd_hit !== 1'b0 || cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL load_fwd_drained: got hit=%b stall=%b, required 0/0", cpu_fwd_hit, cpu_stall);
    end
`else
    n_checks++;
    if (cpu_fwd_hit !== 1'b0 || cpu_fwd_data !== '0 || cpu_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL load_stall_start: got hit=%b data=%h stall=%b, required 0/00000000/1",
               cpu_fwd_hit, cpu_fwd_data, cpu_stall);
    end
    tick();
    mem_ack = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      n_checks++;
      if (cpu_stall !== 1'b1 || cpu_fwd_hit !== 1'b0) begin
        n_fail++;
        $display("FAIL load_stall_drain[%0d]: got stall=%b hit=%b, required 1/0",
                 j, cpu_stall, cpu_fwd_hit);
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (cpu_stall !== 1'b0 || cpu_fwd_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL load_stall_release: got stall=%b hit=%b, required 0/0", cpu_stall, cpu_fwd_hit);
    end
`endif
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL load_drain_pending: got %0d, required 0", sb_q.size());
    end
    idle_inputs();
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cpu_we  = 1'b1;
      cpu_adr = 32'h300 + 32'(4 * k);
      cpu_wd  = 32'h30 + 32'(k);
      tick();
    end
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_req_before: got %b, required 1", mem_req);
    end
    tick();
    mon_en  = 1'b0;
    reset   = 1'b1;
    mem_ack = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_req, mem_adr, mem_wd, cpu_stall, cpu_fwd_hit, cpu_fwd_data} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got req=%b adr=%h wd=%h stall=%b hit=%b data=%h, required all 0",
               mem_req, mem_adr, mem_wd, cpu_stall, cpu_fwd_hit, cpu_fwd_data);
    end
    tick();
    cpu_re  = 1'b1;
    cpu_adr = 32'h300;
    @(negedge clk);
    n_checks++;
    if (cpu_fwd_hit !== 1'b0 || cpu_stall !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_empty_load: got hit=%b stall=%b req=%b, required 0/0/0",
               cpu_fwd_hit, cpu_stall, mem_req);
    end
    tick();
    idle_inputs();
    tick();
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_no_req: got %b, required 0", mem_req);
    end
    tick();
    mem_ack = 1'b0;
    mon_en  = 1'b1;
    cpu_we  = 1'b1;
    cpu_adr = 32'h320;
    cpu_wd  = 32'h44;
    sb_q.push_back({cpu_adr, cpu_wd});
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || mem_adr !== 32'h320 || mem_wd !== 32'h44) begin
      n_fail++;
      $display("FAIL rstmid_new_store: got req=%b adr=%h wd=%h, required 1/00000320/00000044",
               mem_req, mem_adr, mem_wd);
    end
    tick();
    mem_ack = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL rstmid_new_drain: got req=%b pending=%0d, required 0/0", mem_req, sb_q.size());
    end
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    int            issued;
    int            mcnt;
    int            cyc;
    bit            enq;
    bit            deq;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    issued = 0;
    mcnt   = 0;
    cyc    = 0;
    a      = $urandom;
    d      = $urandom;
    while ((issued < 10 || mcnt != 0) && cyc < 300) begin
      mem_ack = ($urandom_range(0, 2) == 0);
      cpu_we  = (issued < 10);
      cpu_adr = a;
      cpu_wd  = d;
      @(negedge clk);
      n_checks++;
      if (mem_req !== (mcnt != 0)) begin
        n_fail++;
        $display("FAIL wrap_req[%0d]: got %b, required %b", cyc, mem_req, mcnt != 0);
      end
      if (cpu_we) begin
        n_checks++;
        if (cpu_stall !== (mcnt == DEPTH)) begin
          n_fail++;
          $display("FAIL wrap_stall[%0d]: got %b, required %b", cyc, cpu_stall, mcnt == DEPTH);
        end
      end
      enq = cpu_we && (mcnt < DEPTH);
      deq = (mcnt != 0) && mem_ack;
      if (enq) begin
        sb_q.push_back({a, d});
        issued++;
        a = $urandom;
        d = $urandom;
      end
      mcnt = mcnt + int'(enq) - int'(deq);
      tick();
      cyc++;
    end
    idle_inputs();
    mem_ack = 1'b0;
    n_checks++;
    if (cyc >= 300) begin
      n_fail++; $display("FAIL wrap_timeout: got %0d cycles, required < 300", cyc);
    end
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_end: got req=%b pending=%0d, required 0/0", mem_req, sb_q.size());
    end
    tick();
  endtask

  initial begin
    reset   = 1'b1;
    mem_ack = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_fill_stall();
    test_full_ack_pulse();
    test_load();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
